// File: rtl/snp_bus_arbiter_pkg.sv
// Shared snoop-bus definitions: request/response codes and controller state type.
package cache_def;

  localparam logic [2:0] SNP_NO_REQ = 3'd0;
  localparam logic [2:0] SNP_RD     = 3'd1;
  localparam logic [2:0] SNP_RWITM  = 3'd2;
  localparam logic [2:0] SNP_INV    = 3'd3;

  localparam logic [1:0] SNP_NO_RSP = 2'd0;
  localparam logic [1:0] SNP_FOUND  = 2'd1;
  localparam logic [1:0] SNP_FETCH  = 2'd2;

  typedef enum logic [1:0] {IDLE, BCAST, COLLECT, RESP} snp_bus_st_t;

endpackage

// File: rtl/snp_bus_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first requester after last_gnt, wrapping around.
module rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] last_gnt,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            gnt_valid
);

  int unsigned idx;

  // Walk offsets from farthest to nearest so the nearest requester is written last.
  always_comb begin
    gnt       = '0;
    gnt_id    = '0;
    gnt_valid = 1'b0;
    idx       = 0;
    for (int unsigned off = N; off >= 1; off--) begin
      idx = (int'(last_gnt) + off) % N;
      if (req[idx]) begin
        gnt       = '0;
        gnt[idx]  = 1'b1;
        gnt_id    = ID_W'(idx);
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/snp_bus_arbiter.sv
// Snoop-bus controller: arbitrates L1 snoop requests, broadcasts, collects acks, responds.
module snp_bus_arbiter
  import cache_def::*;
#(
  parameter int unsigned NUM_CORE = 4,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned TIMEOUT  = 15,
  localparam int unsigned ID_W    = (NUM_CORE > 1) ? $clog2(NUM_CORE) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CORE*3-1:0]      req_snp,
  input  logic [NUM_CORE*ADDR_W-1:0] req_addr,
  output logic [NUM_CORE*2-1:0]      rsp_snp,
  output logic                       bc_valid,
  output logic [2:0]                 bc_req,
  output logic [ADDR_W-1:0]          bc_addr,
  output logic [ID_W-1:0]            bc_src,
  output logic [NUM_CORE-1:0]        bc_tgt,
  input  logic [NUM_CORE-1:0]        snp_ack,
  input  logic [NUM_CORE-1:0]        snp_hit,
  output logic                       busy,
  output logic                       timeout_err
);

  snp_bus_st_t state_q;

  logic [NUM_CORE*2-1:0] rsp_snp_q;
  logic                  bc_valid_q;
  logic [2:0]            bc_req_q;
  logic [ADDR_W-1:0]     bc_addr_q;
  logic [ID_W-1:0]       bc_src_q;
  logic [NUM_CORE-1:0]   bc_tgt_q;
  logic                  timeout_err_q;
  logic [ID_W-1:0]       last_gnt_q;
  logic [NUM_CORE-1:0]   pending_q;
  logic [NUM_CORE-1:0]   hit_acc_q;
  logic [7:0]            cnt_q;

  logic [NUM_CORE-1:0] req_vec;
  logic [NUM_CORE-1:0] arb_gnt;
  logic [ID_W-1:0]     arb_id;
  logic                arb_valid;
  logic [2:0]          sel_req;
  logic [ADDR_W-1:0]   sel_addr;
  logic [NUM_CORE-1:0] hit_next;
  logic                collect_done;
  logic                collect_tmo;
  logic [1:0]          rsp_code;

  rr_arbiter #(
    .N (NUM_CORE)
  ) u_rr_arbiter (
    .req       (req_vec),
    .last_gnt  (last_gnt_q),
    .gnt       (arb_gnt),
    .gnt_id    (arb_id),
    .gnt_valid (arb_valid)
  );

  always_comb begin
    req_vec  = '0;
    sel_req  = SNP_NO_REQ;
    sel_addr = '0;
    for (int i = 0; i < NUM_CORE; i++) begin
      req_vec[i] = req_snp[i*3 +: 3] != SNP_NO_REQ;
      if (ID_W'(i) == arb_id) begin
        sel_req  = req_snp[i*3 +: 3];
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // Final-cycle acks count toward both completion and the hit result.
  assign hit_next     = hit_acc_q | (snp_ack & snp_hit & pending_q);
  assign collect_done = (pending_q & ~snp_ack) == '0;
  assign collect_tmo  = cnt_q == 8'(TIMEOUT - 1);
  assign rsp_code     = ((bc_req_q == SNP_INV) || (hit_next != '0)) ? SNP_FOUND : SNP_FETCH;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rsp_snp_q     <= '0;
      bc_valid_q    <= 1'b0;
      bc_req_q      <= '0;
      bc_addr_q     <= '0;
      bc_src_q      <= '0;
      bc_tgt_q      <= '0;
      timeout_err_q <= 1'b0;
      last_gnt_q    <= ID_W'(NUM_CORE - 1);
      pending_q     <= '0;
      hit_acc_q     <= '0;
      cnt_q         <= '0;
    end else begin
      bc_valid_q    <= 1'b0;
      rsp_snp_q     <= '0;
      timeout_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (arb_valid) begin
            bc_src_q   <= arb_id;
            bc_req_q   <= sel_req;
            bc_addr_q  <= sel_addr;
            bc_tgt_q   <= ~arb_gnt;
            bc_valid_q <= 1'b1;
            state_q    <= BCAST;
          end
        end
        BCAST: begin
          pending_q <= bc_tgt_q;
          hit_acc_q <= '0;
          cnt_q     <= '0;
          state_q   <= COLLECT;
        end
        COLLECT: begin
          pending_q <= pending_q & ~snp_ack;
          hit_acc_q <= hit_next;
          cnt_q     <= cnt_q + 8'd1;
          if (collect_done || collect_tmo) begin
            for (int i = 0; i < NUM_CORE; i++) begin
              if (ID_W'(i) == bc_src_q) rsp_snp_q[i*2 +: 2] <= rsp_code;
            end
            timeout_err_q <= !collect_done;
            bc_tgt_q      <= '0;
            state_q       <= RESP;
          end
        end
        RESP: begin
          last_gnt_q <= bc_src_q;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_snp     = rsp_snp_q;
  assign bc_valid    = bc_valid_q;
  assign bc_req      = bc_req_q;
  assign bc_addr     = bc_addr_q;
  assign bc_src      = bc_src_q;
  assign bc_tgt      = bc_tgt_q;
  assign timeout_err = timeout_err_q;
  assign busy        = state_q != IDLE;

endmodule

// File: tb/tb_snp_bus_arbiter.sv
// Self-checking bench for snp_bus_arbiter: vector table, corner sequences, random traffic.
module tb_snp_bus_arbiter;
  import cache_def::*;

  localparam int NC = 4;
  localparam int AW = 32;
  localparam int TO = 15;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NC*3-1:0] req_snp;
  logic [NC*AW-1:0] req_addr;
  logic [NC*2-1:0] rsp_snp;
  logic            bc_valid;
  logic [2:0]      bc_req;
  logic [AW-1:0]   bc_addr;
  logic [1:0]      bc_src;
  logic [NC-1:0]   bc_tgt;
  logic [NC-1:0]   snp_ack;
  logic [NC-1:0]   snp_hit;
  logic            busy;
  logic            timeout_err;

  snp_bus_arbiter #(
    .NUM_CORE (NC),
    .ADDR_W   (AW),
    .TIMEOUT  (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_snp     (req_snp),
    .req_addr    (req_addr),
    .rsp_snp     (rsp_snp),
    .bc_valid    (bc_valid),
    .bc_req      (bc_req),
    .bc_addr     (bc_addr),
    .bc_src      (bc_src),
    .bc_tgt      (bc_tgt),
    .snp_ack     (snp_ack),
    .snp_hit     (snp_hit),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Requester-side view: what each core is currently holding.
  logic [2:0]  code_a [NC];
  logic [31:0] addr_a [NC];
  int          last_gnt;

  typedef struct {
    int              core;
    logic [2:0]      code;
    logic [31:0]     addr;
    logic [3:0][7:0] dly;   // ack cycle after bc_valid, 0 = never acks
    logic [3:0]      hit;
    logic [1:0]      exp_rsp;
    bit              exp_to;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic apply_req();
    for (int i = 0; i < NC; i++) begin
      req_snp[i*3 +: 3]   = code_a[i];
      req_addr[i*AW +: AW] = addr_a[i];
    end
  endtask

  function automatic int next_grant();
    for (int off = 1; off <= NC; off++) begin
      if (code_a[(last_gnt + off) % NC] != SNP_NO_REQ) return (last_gnt + off) % NC;
    end
    return -1;
  endfunction

  // Reference outcome: only non-requesting cores that ack within the window contribute.
  function automatic void model(input int src, input logic [2:0] code,
                                input logic [3:0][7:0] dly, input logic [3:0] hit,
                                output logic [1:0] rsp, output bit to);
    bit any_hit = 0;
    to = 0;
    for (int i = 0; i < NC; i++) begin
      if (i != src) begin
        if (dly[i] == 0 || dly[i] > TO) to = 1;
        else if (hit[i]) any_hit = 1;
      end
    end
    rsp = (code == SNP_INV || any_hit) ? SNP_FOUND : SNP_FETCH;
  endfunction

  task automatic run_txn(input string nm, input int src, input logic [1:0] exp_rsp,
                         input bit exp_to, input logic [3:0][7:0] dly, input logic [3:0] hit);
    bit           found = 0;
    bit           early = 0;
    bit           all_ack = 1;
    int           done = 1;
    int           exp_k;
    logic [3:0]   exp_tgt;
    logic [7:0]   exp_vec;
    for (int i = 0; i < NC; i++) begin
      if (i != src) begin
        if (dly[i] == 0 || dly[i] > TO) all_ack = 0;
        else if (int'(dly[i]) > done) done = int'(dly[i]);
      end
    end
    if (!all_ack) done = TO;
    exp_k   = done + 1;
    exp_tgt = 4'hf & ~(4'b1 << src);
    exp_vec = '0;
    exp_vec[src*2 +: 2] = exp_rsp;

    for (int w = 0; w < 40; w++) begin
      @(negedge clk);
      if (bc_valid) begin
        found = 1;
        break;
      end
    end
    chk({nm, " bc_seen"}, 64'(found), 64'd1);
    if (!found) return;
    chk({nm, " bc_src"}, 64'(bc_src), 64'(src));
    chk({nm, " bc_tgt"}, 64'(bc_tgt), 64'(exp_tgt));
    chk({nm, " bc_req"}, 64'(bc_req), 64'(code_a[src]));
    chk({nm, " bc_addr"}, 64'(bc_addr), 64'(addr_a[src]));

    for (int k = 1; k <= exp_k; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk({nm, " bc_one_cycle"}, 64'(bc_valid), 64'd0);
        chk({nm, " tgt_held"}, 64'(bc_tgt), 64'(exp_tgt));
      end
      if (k < exp_k) begin
        if (rsp_snp != '0 || timeout_err) early = 1;
        for (int i = 0; i < NC; i++) begin
          snp_ack[i] = (int'(dly[i]) == k);
          snp_hit[i] = snp_ack[i] ? hit[i] : 1'b1;
        end
      end else begin
        chk({nm, " rsp_snp"}, 64'(rsp_snp), 64'(exp_vec));
        chk({nm, " timeout_err"}, 64'(timeout_err), 64'(exp_to));
        chk({nm, " busy_resp"}, 64'(busy), 64'd1);
        snp_ack = '0;
        snp_hit = '0;
        code_a[src] = SNP_NO_REQ;
        apply_req();
      end
    end
    chk({nm, " no_early_rsp"}, 64'(early), 64'd0);
    last_gnt = src;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    last_gnt = NC - 1;
  endtask

  initial begin
    logic [3:0][7:0] dly;
    logic [3:0]      hit;
    logic [1:0]      mrsp;
    bit              mto;
    int              g;
    int              r;

    rst_n   = 1'b0;
    snp_ack = '0;
    snp_hit = '0;
    for (int i = 0; i < NC; i++) begin
      code_a[i] = SNP_NO_REQ;
      addr_a[i] = '0;
    end
    apply_req();
    last_gnt = NC - 1;

    #12;
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst bc_valid", 64'(bc_valid), 64'd0);
    chk("rst rsp_snp", 64'(rsp_snp), 64'd0);
    chk("rst bc_tgt", 64'(bc_tgt), 64'd0);
    chk("rst timeout_err", 64'(timeout_err), 64'd0);
    chk("rst bc_src", 64'(bc_src), 64'd0);
    chk("rst bc_addr", 64'(bc_addr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // dly index order is {core3, core2, core1, core0}
    vecs[0] = '{1, SNP_RD,    32'h1000, {8'd1, 8'd1, 8'd0, 8'd1}, 4'b0100, SNP_FOUND, 0};
    vecs[1] = '{0, SNP_RWITM, 32'h2000, {8'd3, 8'd1, 8'd2, 8'd0}, 4'b0000, SNP_FETCH, 0};
    vecs[2] = '{3, SNP_RD,    32'h3000, {8'd0, 8'd2, 8'd0, 8'd1}, 4'b0001, SNP_FOUND, 1};
    vecs[3] = '{3, SNP_RD,    32'h3040, {8'd0, 8'd2, 8'd0, 8'd1}, 4'b0000, SNP_FETCH, 1};
    vecs[4] = '{2, SNP_INV,   32'h4000, {8'd2, 8'd1, 8'd2, 8'd2}, 4'b0100, SNP_FOUND, 0};
    vecs[5] = '{2, SNP_INV,   32'h4400, {8'd1, 8'd0, 8'd1, 8'd1}, 4'b1011, SNP_FOUND, 0};
    vecs[6] = '{1, SNP_RWITM, 32'h5000, {8'd7, 8'd3, 8'd0, 8'd5}, 4'b1000, SNP_FOUND, 0};
    vecs[7] = '{0, SNP_RD,    32'h6000, {8'd2, 8'd4, 8'd1, 8'd0}, 4'b0000, SNP_FETCH, 0};

    for (int v = 0; v < 8; v++) begin
      code_a[vecs[v].core] = vecs[v].code;
      addr_a[vecs[v].core] = vecs[v].addr;
      apply_req();
      run_txn($sformatf("vec%0d", v), vecs[v].core, vecs[v].exp_rsp, vecs[v].exp_to,
              vecs[v].dly, vecs[v].hit);
    end

    // All four request together: strict 0,1,2,3 order, then 0 and 2 again.
    do_reset();
    code_a = '{SNP_RD, SNP_RWITM, SNP_INV, SNP_RD};
    addr_a = '{32'hA000, 32'hA100, 32'hA200, 32'hA300};
    apply_req();
    dly = {8'd1, 8'd1, 8'd1, 8'd1};
    run_txn("all0", 0, SNP_FETCH, 0, dly, 4'b0000);
    run_txn("all1", 1, SNP_FETCH, 0, dly, 4'b0000);
    run_txn("all2", 2, SNP_FOUND, 0, dly, 4'b0000);
    run_txn("all3", 3, SNP_FETCH, 0, dly, 4'b0000);
    code_a[0] = SNP_RD;
    code_a[2] = SNP_RWITM;
    apply_req();
    run_txn("re0", 0, SNP_FETCH, 0, dly, 4'b0000);
    run_txn("re2", 2, SNP_FETCH, 0, dly, 4'b0000);

    // Reset in COLLECT: outputs clear at once, held request re-granted from core 0.
    code_a[1] = SNP_RD;
    addr_a[1] = 32'hB100;
    apply_req();
    g = 0;
    for (int w = 0; w < 40; w++) begin
      @(negedge clk);
      if (bc_valid) begin
        g = 1;
        break;
      end
    end
    chk("mrst bc_seen", 64'(g), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst busy", 64'(busy), 64'd0);
    chk("mrst rsp_snp", 64'(rsp_snp), 64'd0);
    chk("mrst bc_tgt", 64'(bc_tgt), 64'd0);
    chk("mrst bc_req", 64'(bc_req), 64'd0);
    chk("mrst bc_src", 64'(bc_src), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_gnt = NC - 1;
    code_a[3] = SNP_RWITM;
    addr_a[3] = 32'hB300;
    apply_req();
    run_txn("mrst1", 1, SNP_FOUND, 0, {8'd1, 8'd1, 8'd1, 8'd1}, 4'b0001);
    run_txn("mrst3", 3, SNP_FETCH, 0, {8'd2, 8'd2, 8'd2, 8'd2}, 4'b0000);

    // Random traffic against the reference model.
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < NC; i++) begin
        if (code_a[i] == SNP_NO_REQ && $urandom_range(0, 1) == 1) begin
          code_a[i] = 3'($urandom_range(1, 3));
          addr_a[i] = $urandom;
        end
      end
      apply_req();
      g = next_grant();
      if (g < 0) continue;
      for (int i = 0; i < NC; i++) begin
        r = $urandom_range(0, 19);
        dly[i] = (r == 0) ? 8'd0 : (r == 1) ? 8'(TO + 2) : 8'($urandom_range(1, 5));
        hit[i] = 1'($urandom_range(0, 1));
      end
      model(g, code_a[g], dly, hit, mrsp, mto);
      run_txn($sformatf("rnd%0d", it), g, mrsp, mto, dly, hit);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
